// File: rtl/width_packer_pkg.sv
// width_packer_pkg
//
// Shared definitions for the width packer and its consumers (the downstream
// sync FIFO and whatever reads words out of it).
//
// Contents:
//   cnt_width()     - width of the beat-count field for a given RATIO
//   DEF_IN_W        - default beat width
//   DEF_RATIO       - default beats per packed word
//   DEF_CNT_W       - beat-count field width at the defaults
//   DEF_WORD_W      - packed word width at the defaults
//   packed_word_t   - {nbeats, last, data} at the default widths; the FIFO is
//                     instantiated with this type so producer and consumers
//                     agree on the layout
package width_packer_pkg;

    // nbeats must be able to hold RATIO itself, hence RATIO+1.
    function automatic int cnt_width(input int ratio);
        return $clog2(ratio + 1);
    endfunction

    localparam int DEF_IN_W   = 8;
    localparam int DEF_RATIO  = 4;
    localparam int DEF_CNT_W  = cnt_width(DEF_RATIO);
    localparam int DEF_WORD_W = DEF_RATIO * DEF_IN_W + 1 + DEF_CNT_W;

    typedef struct packed {
        logic [DEF_CNT_W-1:0]          nbeats;
        logic                          last;
        logic [DEF_RATIO*DEF_IN_W-1:0] data;
    } packed_word_t;

endpackage

// File: rtl/width_packer.sv
// width_packer
//
// Packs RATIO consecutive IN_W-bit beats from a valid/ready stream into one
// wide word and writes it into a synchronous FIFO through a write-enable/full
// interface. A beat flagged last closes a partial word early so packet
// boundaries survive the width change. Beat 0 lands in the least significant
// lane; lanes not filled in a partial word read zero.
//
// Build option:
//   WIDTH_PACKER_TIMEOUT_EN - when defined, a partial word that sees TIMEOUT
//                             consecutive idle cycles is flushed to the FIFO
//                             with last=0. When undefined there is no idle
//                             counter and no TIMEOUT parameter.
//
// Parameters:
//   IN_W     width of one input beat
//   RATIO    beats per packed word (>= 2, any value)
//   TIMEOUT  idle cycles before a partial word is flushed (option only)
//   CNT_W    derived beat-count field width, $clog2(RATIO+1)
//
// Ports:
//   clk        in   single clock, all logic on posedge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   beat present
//   in_data    in   beat payload
//   in_last    in   beat closes the current word / packet
//   in_ready   out  beat accepted when in_valid & in_ready at a posedge
//   fifo_wen   out  write strobe to the FIFO
//   fifo_data  out  packed word {nbeats, last, data}
//   fifo_full  in   FIFO full flag (registered inside the FIFO)
module width_packer
    import width_packer_pkg::*;
#(
    parameter int IN_W    = DEF_IN_W,
    parameter int RATIO   = DEF_RATIO,
`ifdef WIDTH_PACKER_TIMEOUT_EN
    parameter int TIMEOUT = 16,
`endif
    localparam int CNT_W  = cnt_width(RATIO),
    localparam int WORD_W = RATIO * IN_W + 1 + CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [IN_W-1:0]   in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              fifo_wen,
    output logic [WORD_W-1:0] fifo_data,
    input  logic              fifo_full
);

    localparam int DATA_W = RATIO * IN_W;

    // Same layout as width_packer_pkg::packed_word_t, sized by this instance.
    typedef struct packed {
        logic [CNT_W-1:0]  nbeats;
        logic              last;
        logic [DATA_W-1:0] data;
    } word_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] acc_q, acc_d;          // lane accumulator
    logic [CNT_W-1:0]  cnt_q, cnt_d;          // next lane to fill, 0..RATIO-1
    word_t             hold_q, hold_d;        // completed word awaiting write
    logic              hold_valid_q, hold_valid_d;

    // ------------------------------------------------------------------
    // Handshake and completion decode
    // ------------------------------------------------------------------
    logic              accept;
    logic              last_lane;
    logic              complete;
    logic              fifo_write;
    logic              flush;
    logic [DATA_W-1:0] acc_new;               // accumulator with this beat merged

    // fifo_full is a registered flag, so in_ready has no combinational path
    // from in_valid / in_last and the hold register can be drained and
    // refilled in the same cycle.
    assign in_ready   = ~hold_valid_q | ~fifo_full;
    assign fifo_write = hold_valid_q & ~fifo_full;
    assign accept     = in_valid & in_ready;
    assign last_lane  = (cnt_q == CNT_W'(RATIO - 1));
    assign complete   = accept & (last_lane | in_last);

    always_comb begin
        acc_new = acc_q;
        for (int i = 0; i < RATIO; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                acc_new[i*IN_W +: IN_W] = in_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Idle timeout (optional)
    // ------------------------------------------------------------------
`ifdef WIDTH_PACKER_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              idle_cycle;

    // Only a partial word with nothing pending in hold ages; while hold is
    // occupied the counter freezes rather than racing the FIFO.
    assign idle_cycle = (cnt_q != '0) & ~accept & ~hold_valid_q;

    // The counter would reach TIMEOUT at this edge: flush instead.
    assign flush = idle_cycle & (idle_q == IDLE_W'(TIMEOUT - 1));

    always_comb begin
        idle_d = idle_q;
        if (accept || flush) begin
            idle_d = '0;
        end else if (idle_cycle) begin
            idle_d = idle_q + IDLE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    assign flush = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state: accumulator, beat counter, holding register
    // ------------------------------------------------------------------
    always_comb begin
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;

        // Drain first; a completion in the same cycle reloads below.
        if (fifo_write) begin
            hold_valid_d = 1'b0;
        end

        if (complete) begin
            hold_d.nbeats = cnt_q + CNT_W'(1);
            hold_d.last   = in_last;
            hold_d.data   = acc_new;
            hold_valid_d  = 1'b1;
            cnt_d         = '0;
            acc_d         = '0;
        end else if (accept) begin
            acc_d = acc_new;
            cnt_d = cnt_q + CNT_W'(1);
        end else if (flush) begin
            // Unfilled lanes are already zero in acc_q.
            hold_d.nbeats = cnt_q;
            hold_d.last   = 1'b0;
            hold_d.data   = acc_q;
            hold_valid_d  = 1'b1;
            cnt_d         = '0;
            acc_d         = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q        <= '0;
            cnt_q        <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign fifo_wen  = fifo_write;
    assign fifo_data = hold_q;

    // ------------------------------------------------------------------
    // Invariants
    // ------------------------------------------------------------------
`ifndef SYNTHESIS
    // The lane counter never wraps past the last lane.
    a_cnt_range : assert property (@(posedge clk) disable iff (!rst_n)
        cnt_q < CNT_W'(RATIO));

    // A held word always carries at least one beat and at most RATIO.
    a_hold_nbeats : assert property (@(posedge clk) disable iff (!rst_n)
        hold_valid_q |-> (hold_q.nbeats != '0) && (hold_q.nbeats <= CNT_W'(RATIO)));

    // No write is ever presented to a full FIFO.
    a_no_write_full : assert property (@(posedge clk) disable iff (!rst_n)
        fifo_wen |-> !fifo_full);
`endif

endmodule

// File: tb/tb_width_packer.sv
// Self-checking bench for width_packer (IN_W=8, RATIO=4). A queue-based model
// of the packer predicts in_ready, fifo_wen and fifo_data every cycle; a few
// directed sequences pin the model with hand-computed words. Build with
// +define+WIDTH_PACKER_TIMEOUT_EN to exercise the idle flush.
module tb_width_packer;
    import width_packer_pkg::*;

    localparam int IN_W  = 8;
    localparam int RATIO = 4;
    localparam int CNT_W = cnt_width(RATIO);
    localparam int W     = RATIO * IN_W + 1 + CNT_W;
    localparam int TO    = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [7:0]   in_data = '0;
    logic         in_last = 1'b0;
    logic         in_ready;
    logic         fifo_wen;
    logic [W-1:0] fifo_data;
    logic         fifo_full = 1'b0;

    width_packer #(.IN_W(IN_W), .RATIO(RATIO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .fifo_wen  (fifo_wen),
        .fifo_data (fifo_data),
        .fifo_full (fifo_full)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] word(input int nb, input logic last, input logic [31:0] d);
        packed_word_t w;
        w.nbeats = CNT_W'(nb);
        w.last   = last;
        w.data   = d;
        return w;
    endfunction

    // ---------------- behavioural model ----------------
    logic [7:0]   part[$];     // beats of the word being gathered
    logic [W-1:0] exp_q[$];    // completed words not yet written
    int           idle = 0;
    logic         m_accept = 1'b0;
    logic         m_held;

    function automatic logic [W-1:0] mk(input logic last);
        logic [31:0] d = '0;
        for (int i = 0; i < part.size(); i++) d = d | (32'(part[i]) << (8 * i));
        return word(part.size(), last, d);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            part.delete();
            exp_q.delete();
            idle     = 0;
            m_accept = 1'b0;
        end else begin
            m_held   = (exp_q.size() != 0);
            m_accept = in_valid && (!m_held || !fifo_full);
            if (m_held && !fifo_full) void'(exp_q.pop_front());
            if (m_accept) begin
                part.push_back(in_data);
                idle = 0;
                if (part.size() == RATIO || in_last) begin
                    exp_q.push_back(mk(in_last));
                    part.delete();
                end
            end
`ifdef WIDTH_PACKER_TIMEOUT_EN
            else if (part.size() != 0 && !m_held) begin
                idle++;
                if (idle == TO) begin
                    exp_q.push_back(mk(1'b0));
                    part.delete();
                    idle = 0;
                end
            end
`endif
        end
    end

    // ---------------- compare process ----------------
    logic [W-1:0] wr_log[$];
    int           wr_cyc[$];
    logic         exp_wen;

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            exp_wen = (exp_q.size() != 0) && !fifo_full;
            check("in_ready", in_ready, !((exp_q.size() != 0) && fifo_full));
            check("fifo_wen", fifo_wen, exp_wen);
            if (exp_wen && fifo_wen) begin
                check("fifo_data", fifo_data, exp_q[0]);
                wr_log.push_back(fifo_data);
                wr_cyc.push_back(cyc);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        do begin
            tick();
            n++;
        end while (!m_accept && n < 100);
        if (!m_accept) begin
            errors++;
            checks++;
            $display("FAIL send_bound: beat %0h not accepted in %0d cycles", d, n);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check("rst_fifo_wen", fifo_wen, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_fifo_data", fifo_data, '0);
    endtask

    initial begin
        int n;
        int c;

        #3;
        check_reset_outputs();
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Full word, back-to-back, one-cycle latency.
        n = wr_log.size();
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        send(8'h44, 1'b0);
        c = cyc;
        tick();
        check("full_count", wr_log.size(), n + 1);
        if (wr_log.size() > n) begin
            check("full_word", wr_log[n], word(4, 1'b0, 32'h44332211));
            check("full_latency", wr_cyc[n] - c, 1);
        end

        // Early last, then the next beat starts at lane 0.
        n = wr_log.size();
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b1);
        send(8'hCC, 1'b0);
        send(8'hDD, 1'b0);
        send(8'hEE, 1'b0);
        send(8'hFF, 1'b0);
        tick();
        check("early_count", wr_log.size(), n + 2);
        if (wr_log.size() > n + 1) begin
            check("early_word", wr_log[n], word(2, 1'b1, 32'h0000BBAA));
            check("early_next", wr_log[n+1], word(4, 1'b0, 32'hFFEEDDCC));
        end

        // Backpressure: one word held, input stalls, release drains in order.
        n = wr_log.size();
        fifo_full = 1'b1;
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        send(8'h44, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h55;
        for (int i = 0; i < 5; i++) begin
            check("bp_ready_low", in_ready, 1'b0);
            check("bp_no_wen", fifo_wen, 1'b0);
            tick();
        end
        check("bp_no_write", wr_log.size(), n);
        fifo_full = 1'b0;
        send(8'h55, 1'b0);
        send(8'h66, 1'b0);
        send(8'h77, 1'b0);
        send(8'h88, 1'b0);
        tick();
        check("bp_count", wr_log.size(), n + 2);
        if (wr_log.size() > n + 1) begin
            check("bp_word0", wr_log[n], word(4, 1'b0, 32'h44332211));
            check("bp_word1", wr_log[n+1], word(4, 1'b0, 32'h88776655));
        end

        // Mid-word reset discards the partial word.
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        tick();
        tick();
        rst_n = 1'b1;
        n = wr_log.size();
        for (int i = 0; i < 5; i++) tick();
        check("reset_no_write", wr_log.size(), n);
        send(8'hA1, 1'b0);
        send(8'hA2, 1'b0);
        send(8'hA3, 1'b0);
        send(8'hA4, 1'b0);
        tick();
        check("reset_clean_count", wr_log.size(), n + 1);
        if (wr_log.size() > n) check("reset_clean_word", wr_log[n], word(4, 1'b0, 32'hA4A3A2A1));

        // Lone beat then idle: flushed after TIMEOUT idle cycles, or held forever.
        n = wr_log.size();
        send(8'h5A, 1'b0);
        c = cyc;
        for (int i = 0; i < 40; i++) tick();
`ifdef WIDTH_PACKER_TIMEOUT_EN
        check("timeout_count", wr_log.size(), n + 1);
        if (wr_log.size() > n) begin
            check("timeout_word", wr_log[n], word(1, 1'b0, 32'h0000005A));
            // 16 idle cycles after the beat's edge, then the write cycle.
            check("timeout_latency", wr_cyc[n] - c, TO + 1);
        end
`else
        check("no_timeout_write", wr_log.size(), n);
        send(8'h5B, 1'b1);
        tick();
        check("no_timeout_close", wr_log.size(), n + 1);
        if (wr_log.size() > n) check("no_timeout_word", wr_log[n], word(2, 1'b1, 32'h00005B5A));
`endif

        // Randomized traffic with bursty backpressure.
        for (int i = 0; i < 3000; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = 8'($urandom);
            in_last  = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 7) == 0) fifo_full = ~fifo_full;
            if ((i % 500) > 470) in_valid = 1'b0;   // occasional long idle gaps
            tick();
        end
        in_valid  = 1'b0;
        fifo_full = 1'b0;
        for (int i = 0; i < 5; i++) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
